// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: multi-cycle wide adder that reuses one CHUNK-bit ripple-carry
// slice, one chunk per clock, LSB chunk first, carry held in a register.
// Optional feature macro: RCA_SEQ_SUB_EN adds a 'sub' input for a - b.

// Combinational CHUNK-bit ripple-carry adder slice.
module rca_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic carry;

  // Ripple the carry bit by bit through the slice.
  always_comb begin
    s     = '0;
    carry = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    co = carry;
  end

endmodule

module rca_seq_ctrl #(
  parameter int unsigned CHUNK  = 8,
  parameter int unsigned NCHUNK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CHUNK*NCHUNK-1:0] a,
  input  logic [CHUNK*NCHUNK-1:0] b,
  input  logic                    cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                    sub,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [CHUNK*NCHUNK-1:0] out,
  output logic                    cout
);

  localparam int unsigned W    = CHUNK * NCHUNK;
  localparam int unsigned IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    acc_q,   acc_d;
  logic [W-1:0]    out_q,   out_d;
  logic            cout_q,  cout_d;

  logic [W-1:0]     b_in;
  logic             cin_in;
  logic [CHUNK-1:0] slice_x;
  logic [CHUNK-1:0] slice_y;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;

`ifdef RCA_SEQ_SUB_EN
  // Subtraction is a + ~b + 1, so invert b and force the initial carry.
  always_comb begin
    b_in   = sub ? ~b : b;
    cin_in = sub ? 1'b1 : cin;
  end
`else
  // Addition only: operands pass straight through.
  always_comb begin
    b_in   = b;
    cin_in = cin;
  end
`endif

  // Select the current chunk of each operand for the shared slice.
  always_comb begin
    slice_x = a_q[idx_q*CHUNK +: CHUNK];
    slice_y = b_q[idx_q*CHUNK +: CHUNK];
  end

  rca_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_cout)
  );

  // Sequencer next-state: accept in IDLE/DONE, one chunk per RUN cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    out_d   = out_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = cin_in;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d[idx_q*CHUNK +: CHUNK] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          // Publish the accumulator including the chunk written this cycle.
          out_d   = acc_d;
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
    end
  end

  // Status and result outputs decoded from registers only.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    out  = out_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Testbench for rca_seq_ctrl: table-driven vectors plus hand-written sequences
// for ignored start, back-to-back, mid-run reset and NCHUNK=1.
module tb_rca_seq_ctrl;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_out;
    logic         exp_cout;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] out_s;
  logic         cout;
`ifdef RCA_SEQ_SUB_EN
  logic         sub_i;
`endif

  logic         start1;
  logic [7:0]   a1;
  logic [7:0]   b1;
  logic         cin1;
  logic         busy1;
  logic         done1;
  logic [7:0]   out1;
  logic         cout1;

  int unsigned n_cmp;
  int unsigned n_err;

  rca_seq_ctrl #(
    .CHUNK  (8),
    .NCHUNK (4)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef RCA_SEQ_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .out   (out_s),
    .cout  (cout)
  );

  rca_seq_ctrl #(
    .CHUNK  (8),
    .NCHUNK (1)
  ) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
`ifdef RCA_SEQ_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy1),
    .done  (done1),
    .out   (out1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string nm);
    int unsigned  lat;
    logic         seen;
    logic [W-1:0] prev_out;
    prev_out = out_s;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
`ifdef RCA_SEQ_SUB_EN
    sub_i = v.sub;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    check({nm, "_busy"}, {63'd0, busy}, 64'd1);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      seen = done;
      if (!seen) check({nm, "_out_hold"}, {32'd0, out_s}, {32'd0, prev_out});
    end
    check({nm, "_done"}, {63'd0, seen}, 64'd1);
    check({nm, "_lat"}, 64'(lat), 64'd4);
    check({nm, "_out"}, {32'd0, out_s}, {32'd0, v.exp_out});
    check({nm, "_cout"}, {63'd0, cout}, {63'd0, v.exp_cout});
    check({nm, "_busy_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    vec_t         vecs[$];
    vec_t         v;
    int unsigned  cyc;
    int unsigned  ndone;
    logic         seen;

    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    sub_i = 1'b0;
`endif

    vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0});
    vecs.push_back('{32'hDEADBEEF, 32'h01234567, 1'b0, 1'b0, 32'hDFD10456, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0});
`ifdef RCA_SEQ_SUB_EN
    vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1});
    vecs.push_back('{32'h00001234, 32'h00001234, 1'b0, 1'b1, 32'h00000000, 1'b1});
`endif

    // Reset state
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_out", {32'd0, out_s}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      v = vecs[i];
      run_op(v, $sformatf("vec%0d", i));
    end

    // start pulse during RUN is ignored
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); a = '0; b = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        check("ign_out", {32'd0, out_s}, 64'h23456789);
        check("ign_cout", {63'd0, cout}, 64'd0);
      end
    end
    check("ign_ndone", 64'(ndone), 64'd1);

    // Back-to-back start accepted from DONE
    @(negedge clk);
    a = 32'h00000001; b = 32'h00000001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin @(posedge clk); #1; cyc++; seen = done; end
    check("b2b_first_done", {63'd0, seen}, 64'd1);
    check("b2b_first_out", {32'd0, out_s}, 64'h2);
    check("b2b_first_cout", {63'd0, cout}, 64'd0);
    @(negedge clk); a = 32'h80000000; b = 32'h80000000;
    @(posedge clk); #1; start = 1'b0;
    check("b2b_accept_busy", {63'd0, busy}, 64'd1);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 20) begin @(posedge clk); #1; cyc++; seen = done; end
    check("b2b_second_done", {63'd0, seen}, 64'd1);
    check("b2b_gap", 64'(cyc), 64'd5);
    check("b2b_second_out", {32'd0, out_s}, 64'h0);
    check("b2b_second_cout", {63'd0, cout}, 64'd1);

    // Reset mid-RUN aborts
    v = '{32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b0, 32'h0F0F0F0F, 1'b0};
    run_op(v, "pre_rst");
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h00000001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_out", {32'd0, out_s}, 64'd0);
    check("abort_cout", {63'd0, cout}, 64'd0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    v = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0};
    run_op(v, "post_rst");

    // NCHUNK=1 instance: single RUN cycle
    @(negedge clk);
    a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    check("n1_busy", {63'd0, busy1}, 64'd1);
    @(posedge clk); #1;
    check("n1_done", {63'd0, done1}, 64'd1);
    check("n1_out", {56'd0, out1}, 64'h00);
    check("n1_cout", {63'd0, cout1}, 64'd1);
    @(posedge clk); #1;
    check("n1_idle", {63'd0, done1}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
